// File: rtl/rfc_pkg.sv
// Shared definitions for the rfc_host bank controller: op encoding and FSM state type.
package rfc_pkg;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        CAP  = 3'd3,
        RESP = 3'd4
    } rfc_state_t;

endpackage

// File: rtl/rfc_addr_dec.sv
// Cell address decoder: AW-bit index to DEPTH-bit one-hot, with an in-range flag.
module rfc_addr_dec #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0]    i_addr,
    output logic [DEPTH-1:0] o_onehot,
    output logic             o_in_range
);

    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_onehot[i] = (i_addr == AW'(i));
        end
    end

    // An index at or beyond DEPTH matches no cell, so the one-hot is empty.
    assign o_in_range = |o_onehot;

endmodule

// File: rtl/rfc_host.sv
// Host-side controller for a bank of DEPTH 1-bit cells: one request at a time,
// write/read sequencing and a held response. RFC_HOST_VERIFY_EN adds write readback.
module rfc_host
    import rfc_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [AW-1:0]    req_addr,
    input  logic             req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_rdata,
    output logic             resp_err,
    output logic [DEPTH-1:0] cell_write_en,
    output logic [DEPTH-1:0] cell_read_en,
    output logic             cell_data_in,
    input  logic [DEPTH-1:0] cell_data_out,
    output rfc_state_t       dbg_state
);

    rfc_state_t       r_state;
    rfc_state_t       w_state_nxt;
    logic [AW-1:0]    r_addr;
    logic             r_wdata;
    logic             r_rdata;
    logic             r_err;
    logic [DEPTH-1:0] w_onehot;
    logic             w_in_range;
    logic             w_readback;
    logic             w_accept;
`ifdef RFC_HOST_VERIFY_EN
    logic             r_op;
`endif

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid and its payload stay stable until that edge, ready may drop anytime.
    assign w_accept = req_valid && req_ready;

    rfc_addr_dec #(.DEPTH(DEPTH)) u_addr_dec (
        .i_addr     (r_addr),
        .o_onehot   (w_onehot),
        .o_in_range (w_in_range)
    );

    assign w_readback = |(w_onehot & cell_data_out);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        cell_write_en = '0;
        cell_read_en  = '0;
        cell_data_in  = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = (req_op == OP_WR) ? WR : RD;
                end
            end
            WR: begin
                cell_write_en = w_onehot;
                cell_data_in  = r_wdata;
`ifdef RFC_HOST_VERIFY_EN
                w_state_nxt   = RD;
`else
                w_state_nxt   = RESP;
`endif
            end
            RD: begin
                cell_read_en = w_onehot;
                w_state_nxt  = CAP;
            end
            CAP: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_wdata <= 1'b0;
            r_rdata <= 1'b0;
            r_err   <= 1'b0;
`ifdef RFC_HOST_VERIFY_EN
            r_op    <= OP_RD;
`endif
        end else begin
            if (w_accept) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
`ifdef RFC_HOST_VERIFY_EN
                r_op    <= req_op;
`endif
            end
            // Out-of-range addresses enable no cell, so the readback is 0 there.
            if (r_state == CAP) begin
                r_rdata <= w_readback;
`ifdef RFC_HOST_VERIFY_EN
                r_err   <= !w_in_range || ((r_op == OP_WR) && (w_readback != r_wdata));
`else
                r_err   <= !w_in_range;
`endif
            end
`ifndef RFC_HOST_VERIFY_EN
            if (r_state == WR) begin
                r_rdata <= 1'b0;
                r_err   <= !w_in_range;
            end
`endif
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign dbg_state  = r_state;

endmodule
